dmem_responder: RTL and testbench

Data-memory responder at the far end of the CPU's MEM-stage interface, serving the loads and stores the pipeline issues through its read-enable, write-enable, address and write-data outputs. It services one access at a time with a parameterised latency. Stores are byte-lane masked; loads are sign- or zero-extended by RISC-V funct3. Misaligned, out-of-range and illegal requests are rejected. A stall output holds the pipeline until the response is ready.

---
 rtl/dmem_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one access at a time, fixed latency,
// byte-lane masked stores, funct3-extended loads and fault rejection.
//
// state | meaning
// IDLE  | waiting for a load or store request
// WAIT  | access accepted, counting down the remaining latency
// RESP  | rsp_valid high for this single cycle
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_r_en,
  input  logic        req_w_en,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req_present;
  logic          accept;
  logic          op_bad;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic          do_write;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [31:0]   result;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   pend_rdata;
  logic          pend_err;

  assign req_present = req_r_en | req_w_en;
  assign accept      = (state == IDLE) && req_present;
  assign busy        = req_present && (state != RESP);
  assign idx         = req_addr[AW+1:2];
  assign rd_word     = mem[idx];

  always_comb begin
    op_bad = 1'b0;
    case (req_op)
      3'b000, 3'b001, 3'b010: op_bad = 1'b0;
      3'b100, 3'b101:         op_bad = req_w_en;
      default:                op_bad = 1'b1;
    endcase
  end

  assign misaligned   = (((req_op == 3'b001) || (req_op == 3'b101)) && req_addr[0]) ||
                        ((req_op == 3'b010) && (req_addr[1:0] != 2'b00));
  // Any address bit above the array index makes the word index >= DEPTH_WORDS.
  assign out_of_range = |req_addr[31:AW+2];
  assign fault        = (req_r_en & req_w_en) | op_bad | misaligned | out_of_range;
  assign do_write     = accept & req_w_en & ~fault;

  always_comb begin
    rd_shift = rd_word >> {req_addr[1:0], 3'b000};
    ld_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data  = 32'h0;
    case (req_op)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'h0, rd_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
    result = (fault || !req_r_en) ? 32'h0 : ld_data;
  end

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = req_wdata;
    case (req_op[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << req_addr[1:0];
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{req_wdata[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  // Storage is deliberately not reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      pend_rdata <= 32'h0;
      pend_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (accept) begin
            if (LAT == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= result;
              rsp_err   <= fault;
            end else begin
              state      <= WAIT;
              cnt        <= 4'(LAT - 1);
              pend_rdata <= result;
              pend_err   <= fault;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= pend_rdata;
            rsp_err   <= pend_err;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at LAT 1/4/8/3 share clock and reset;
// expected responses are queued at drive time and compared when rsp_valid fires.
module tb_dmem_responder;

  localparam int NI          = 4;
  localparam int DEPTH       = 1024;
  localparam int LATS [NI]   = '{1, 4, 8, 3};

  logic        clk;
  logic        rst_n;
  logic        req_r_en  [NI];
  logic        req_w_en  [NI];
  logic [31:0] req_addr  [NI];
  logic [2:0]  req_op    [NI];
  logic [31:0] req_wdata [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cur      = 0;
  logic [32:0] sbq [$];

  localparam logic [2:0] OP_B = 3'b000, OP_H = 3'b001, OP_W = 3'b010,
                         OP_BU = 3'b100, OP_HU = 3'b101, OP_BAD = 3'b011;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LAT(LATS[0])) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en[0]), .req_w_en(req_w_en[0]),
    .req_addr(req_addr[0]), .req_op(req_op[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LAT(LATS[1])) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en[1]), .req_w_en(req_w_en[1]),
    .req_addr(req_addr[1]), .req_op(req_op[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LAT(LATS[2])) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en[2]), .req_w_en(req_w_en[2]),
    .req_addr(req_addr[2]), .req_op(req_op[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .LAT(LATS[3])) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_r_en(req_r_en[3]), .req_w_en(req_w_en[3]),
    .req_addr(req_addr[3]), .req_op(req_op[3]), .req_wdata(req_wdata[3]),
    .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]), .rsp_err(rsp_err[3]), .busy(busy[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response on the active instance pops one entry.
  always @(negedge clk) begin
    if (rsp_valid[cur] === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata[cur], e[31:0]);
        chk("rsp_err", {31'h0, rsp_err[cur]}, {31'h0, e[32]});
      end
    end
  end

  task automatic drive(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [2:0] op, input logic [31:0] wd);
    req_r_en[k]  = r;
    req_w_en[k]  = w;
    req_addr[k]  = a;
    req_op[k]    = op;
    req_wdata[k] = wd;
  endtask

  // Called #1 after a rising edge; request held through the RESP cycle.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [2:0] op, input logic [31:0] wd,
                        input logic [31:0] exp_d, input bit exp_e);
    int lat;
    lat = LATS[k];
    cur = k;
    sbq.push_back({exp_e, exp_d});
    drive(k, r, w, a, op, wd);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clk);
      chk("busy", {31'h0, busy[k]}, {31'h0, (i < lat)});
      chk("valid_timing", {31'h0, rsp_valid[k]}, {31'h0, (i == lat)});
      @(posedge clk); #1;
    end
    drive(k, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
  endtask

  // Accept an access, then reset partway through its latency: no response may follow.
  task automatic abort(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [2:0] op, input logic [31:0] wd, input int wait_cyc);
    cur = k;
    drive(k, r, w, a, op, wd);
    @(posedge clk); #1;
    drive(k, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    repeat (wait_cyc) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'h0, rsp_valid[k]}, 32'h0);
    chk("abort_rdata", rsp_rdata[k], 32'h0);
    chk("abort_err", {31'h0, rsp_err[k]}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'h0, rsp_valid[k]}, 32'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) drive(k, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    req_r_en[0] = 1'b1;
    @(negedge clk);
    chk("reset_busy_req", {31'h0, busy[0]}, 32'd1);
    chk("reset_busy_idle", {31'h0, busy[1]}, 32'd0);
    for (int k = 0; k < NI; k++) begin
      chk("reset_valid", {31'h0, rsp_valid[k]}, 32'h0);
      chk("reset_rdata", rsp_rdata[k], 32'h0);
      chk("reset_err", {31'h0, rsp_err[k]}, 32'h0);
    end
    req_r_en[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LAT=1: store then sign/zero-extended loads
    access(0, 0, 1, 32'h10, OP_W, 32'h8000_00F1, 32'h0, 0);
    access(0, 1, 0, 32'h10, OP_B, 32'h0, 32'hFFFF_FFF1, 0);
    access(0, 1, 0, 32'h10, OP_BU, 32'h0, 32'h0000_00F1, 0);
    access(0, 1, 0, 32'h12, OP_H, 32'h0, 32'hFFFF_8000, 0);
    access(0, 1, 0, 32'h12, OP_HU, 32'h0, 32'h0000_8000, 0);
    access(0, 1, 0, 32'h13, OP_B, 32'h0, 32'hFFFF_FF80, 0);

    // Byte-lane stores assemble a word
    access(0, 0, 1, 32'h40, OP_B, 32'hAAAA_AA11, 32'h0, 0);
    access(0, 0, 1, 32'h41, OP_B, 32'hBBBB_BB22, 32'h0, 0);
    access(0, 0, 1, 32'h42, OP_B, 32'hCCCC_CC33, 32'h0, 0);
    access(0, 0, 1, 32'h43, OP_B, 32'hDDDD_DD44, 32'h0, 0);
    access(0, 1, 0, 32'h40, OP_W, 32'h0, 32'h4433_2211, 0);
    access(0, 1, 0, 32'h42, OP_HU, 32'h0, 32'h0000_4433, 0);

    // Faults never write memory
    access(0, 0, 1, 32'h0, OP_W, 32'hCAFE_F00D, 32'h0, 0);
    access(0, 1, 0, 32'h02, OP_W, 32'h0, 32'h0, 1);
    access(0, 0, 1, 32'h01, OP_H, 32'hFFFF_FFFF, 32'h0, 1);
    access(0, 1, 0, 32'h0, OP_BAD, 32'h0, 32'h0, 1);
    access(0, 1, 1, 32'h0, OP_W, 32'hFFFF_FFFF, 32'h0, 1);
    access(0, 0, 1, DEPTH * 4, OP_W, 32'hFFFF_FFFF, 32'h0, 1);
    access(0, 0, 1, 32'h0, OP_BU, 32'hFFFF_FFFF, 32'h0, 1);
    access(0, 1, 0, 32'h0, OP_W, 32'h0, 32'hCAFE_F00D, 0);

    // LAT=4: halfword store keeps the other half
    access(1, 0, 1, 32'h20, OP_W, 32'h1234_5678, 32'h0, 0);
    access(1, 0, 1, 32'h22, OP_H, 32'h0000_BEEF, 32'h0, 0);
    access(1, 1, 0, 32'h20, OP_W, 32'h0, 32'hBEEF_5678, 0);
    access(1, 1, 0, 32'h23, OP_H, 32'h0, 32'h0, 1);

    // LAT=8: reset mid-WAIT discards a load but keeps a committed store
    access(2, 0, 1, 32'h08, OP_W, 32'h5555_AAAA, 32'h0, 0);
    access(2, 1, 0, 32'h08, OP_W, 32'h0, 32'h5555_AAAA, 0);
    abort(2, 1, 0, 32'h08, OP_W, 32'h0, 3);
    abort(2, 0, 1, 32'h0C, OP_W, 32'h0F0F_0F0F, 2);
    access(2, 1, 0, 32'h0C, OP_W, 32'h0, 32'h0F0F_0F0F, 0);
    access(2, 1, 0, 32'h08, OP_W, 32'h0, 32'h5555_AAAA, 0);

    // LAT=3: request dropped after acceptance still completes exactly once
    access(3, 0, 1, 32'h04, OP_W, 32'h00C0_FFEE, 32'h0, 0);
    cur = 3;
    sbq.push_back({1'b0, 32'h00C0_FFEE});
    drive(3, 1'b1, 1'b0, 32'h04, OP_W, 32'h0);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("drop_valid", {31'h0, rsp_valid[3]}, {31'h0, (i == 3)});
      chk("drop_busy", {31'h0, busy[3]}, 32'h0);
      @(posedge clk); #1;
    end

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
